core_inst_seq: RTL and testbench

//  Instruction sequencer driving the 35-bit inst bundle of the core. It replaces hand-written

---
 rtl/core_pkg.sv | 33 +++
 rtl/seq_slot_cnt.sv | 26 ++
 rtl/core_inst_seq.sv | 248 ++++++++++++++++++++++++
 tb/tb_core_inst_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core instruction sequencer: inst bit positions,
// the idle instruction word and the sequencer state encoding.
package core_pkg;

  localparam int INST_W   = 35;
  localparam int LOAD     = 0;
  localparam int EXECUTE  = 1;
  localparam int L0_WR    = 2;
  localparam int L0_RD    = 3;
  localparam int IFIFO_RD = 4;
  localparam int IFIFO_WR = 5;
  localparam int OFIFO_RD = 6;
  localparam int A_X_LSB  = 7;
  localparam int WEN_X    = 18;
  localparam int CEN_X    = 19;
  localparam int A_P_LSB  = 20;
  localparam int WEN_P    = 31;
  localparam int CEN_P    = 32;
  localparam int ACC      = 33;
  localparam int MODE     = 34;

  // memory enables are active-low, so idle keeps both SRAMs deselected
  localparam logic [INST_W-1:0] INST_IDLE = 35'h1_800C_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLD,
    S_ACT,
    S_DRAIN,
    S_FIN
  } seq_state_t;

endpackage

// File: rtl/seq_slot_cnt.sv
// Up-counter with terminal-count flag; wraps to zero when enabled at the limit.
module seq_slot_cnt #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == limit);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/core_inst_seq.sv
// One-tile instruction sequencer: weight load, activation stream, OFIFO drain.
// Optional drain watchdog enabled by defining SEQ_TIMEOUT_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | inst idle, waiting for start
// S_WLD   | weight rows: xmem read -> l0_wr -> load, pipelined
// S_ACT   | activation rows; pipelined (acc=0) or one slot per row (acc=1)
// S_DRAIN | one ofifo_rd per cycle that ofifo_valid is seen, N in total
// S_FIN   | done pulse, busy low
module core_inst_seq
  import core_pkg::*;
#(
  parameter int row     = 8,
  parameter int MAC_LAT = 9,
  parameter int CNT_W   = 11,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cfg_mode_w,
  input  logic             cfg_acc,
  input  logic [CNT_W-1:0] cfg_w_base,
  input  logic [CNT_W-1:0] cfg_a_base,
  input  logic [CNT_W-1:0] cfg_p_base,
  input  logic [CNT_W-1:0] cfg_n_act,
  input  logic             ofifo_valid,
  output logic [34:0]      inst,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = CNT_W + 1;
  typedef logic [CNT_W:0] cnt_t;

  localparam cnt_t ONE       = cnt_t'(1);
  localparam cnt_t TWO       = cnt_t'(2);
  localparam cnt_t ROW_C     = cnt_t'(row);
  localparam cnt_t WLD_LAST  = cnt_t'(row + 1);
  localparam cnt_t WR_OFF    = cnt_t'(2 + MAC_LAT);
  localparam cnt_t ACT_TAIL  = cnt_t'(1 + MAC_LAT);
  localparam cnt_t SLOT_LAST = cnt_t'(2 + MAC_LAT);
  localparam cnt_t TO_LAST   = cnt_t'(TIMEOUT - 1);

  seq_state_t       state, state_d;
  logic             mode_q, acc_q;
  logic [CNT_W-1:0] w_base_q, a_base_q, p_base_q, n_q;
  cnt_t             n_ext;
  logic             accept, state_chg;

  cnt_t idx, idx_lim, ph, ph_lim, pw_off;
  logic idx_en, idx_clr, idx_tc;
  logic ph_en, ph_clr, ph_tc, ph_hold_clr;
  logic rd_issue;

  logic [34:0] inst_d;
  logic        busy_d, done_d;

  assign n_ext     = {1'b0, n_q};
  assign accept    = (state == S_IDLE) && start;
  assign state_chg = (state_d != state);
  assign idx_clr   = state_chg;
  assign ph_clr    = state_chg || ph_hold_clr;
  assign pw_off    = idx - WR_OFF;

`ifdef SEQ_TIMEOUT_EN
  logic to_fire;
  assign to_fire = (state == S_DRAIN) && !ofifo_valid && ph_tc;
`endif

  seq_slot_cnt #(.W(CW)) u_idx_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (idx_clr),
    .en    (idx_en),
    .limit (idx_lim),
    .cnt   (idx),
    .tc    (idx_tc)
  );

  seq_slot_cnt #(.W(CW)) u_ph_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (ph_clr),
    .en    (ph_en),
    .limit (ph_lim),
    .cnt   (ph),
    .tc    (ph_tc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      inst     <= INST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      mode_q   <= 1'b0;
      acc_q    <= 1'b0;
      w_base_q <= '0;
      a_base_q <= '0;
      p_base_q <= '0;
      n_q      <= '0;
    end else begin
      state <= state_d;
      inst  <= inst_d;
      busy  <= busy_d;
      done  <= done_d;
      if (accept) begin
        mode_q   <= cfg_mode_w;
        acc_q    <= cfg_acc;
        w_base_q <= cfg_w_base;
        a_base_q <= cfg_a_base;
        p_base_q <= cfg_p_base;
        n_q      <= cfg_n_act;
      end
    end
  end

`ifdef SEQ_TIMEOUT_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (to_fire) begin
      err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d     = state;
    idx_en      = 1'b0;
    idx_lim     = '0;
    ph_en       = 1'b0;
    ph_lim      = '0;
    ph_hold_clr = 1'b0;
    rd_issue    = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_d = S_WLD;
      S_WLD: begin
        idx_en  = 1'b1;
        idx_lim = WLD_LAST;
        if (idx_tc) state_d = (n_q == '0) ? S_FIN : S_ACT;
      end
      S_ACT: begin
        if (!acc_q) begin
          idx_en  = 1'b1;
          idx_lim = n_ext + ACT_TAIL;
          if (idx_tc) state_d = S_DRAIN;
        end else begin
          // phase counter walks one slot, row index advances at slot end
          ph_en   = 1'b1;
          ph_lim  = SLOT_LAST;
          idx_en  = ph_tc;
          idx_lim = n_ext - ONE;
          if (ph_tc && idx_tc) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        rd_issue    = ofifo_valid;
        idx_en      = ofifo_valid;
        idx_lim     = n_ext - ONE;
        ph_lim      = TO_LAST;
        if (ofifo_valid && idx_tc) state_d = S_FIN;
`ifdef SEQ_TIMEOUT_EN
        ph_en       = !ofifo_valid;
        ph_hold_clr = ofifo_valid;
        if (!ofifo_valid && ph_tc) state_d = S_FIN;
`endif
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inst_d = INST_IDLE;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          busy_d       = 1'b1;
          inst_d[MODE] = cfg_mode_w;
        end
      end
      S_WLD: begin
        busy_d       = 1'b1;
        inst_d[MODE] = mode_q;
        if (idx < ROW_C) begin
          inst_d[CEN_X]             = 1'b0;
          inst_d[A_X_LSB +: CNT_W]  = w_base_q + idx[CNT_W-1:0];
        end
        inst_d[L0_WR] = (idx >= ONE) && (idx <= ROW_C);
        inst_d[LOAD]  = (idx >= TWO);
      end
      S_ACT: begin
        busy_d       = 1'b1;
        inst_d[MODE] = mode_q;
        inst_d[ACC]  = acc_q;
        if (!acc_q) begin
          if (idx < n_ext) begin
            inst_d[CEN_X]            = 1'b0;
            inst_d[A_X_LSB +: CNT_W] = a_base_q + idx[CNT_W-1:0];
          end
          inst_d[IFIFO_WR] = (idx >= ONE) && (idx <= n_ext);
          inst_d[EXECUTE]  = (idx >= TWO) && (idx <= n_ext + ONE);
          if ((idx >= WR_OFF) && (idx <= n_ext + ACT_TAIL)) begin
            inst_d[CEN_P]            = 1'b0;
            inst_d[WEN_P]            = 1'b0;
            inst_d[A_P_LSB +: CNT_W] = p_base_q + pw_off[CNT_W-1:0];
          end
        end else begin
          if (ph == '0) begin
            inst_d[CEN_X]            = 1'b0;
            inst_d[A_X_LSB +: CNT_W] = a_base_q + idx[CNT_W-1:0];
          end
          if (ph == ONE) begin
            inst_d[IFIFO_WR]         = 1'b1;
            inst_d[CEN_P]            = 1'b0;
            inst_d[A_P_LSB +: CNT_W] = p_base_q + idx[CNT_W-1:0];
          end
          inst_d[EXECUTE] = (ph == TWO);
          if (ph == SLOT_LAST) begin
            inst_d[CEN_P]            = 1'b0;
            inst_d[WEN_P]            = 1'b0;
            inst_d[A_P_LSB +: CNT_W] = p_base_q + idx[CNT_W-1:0];
          end
        end
      end
      S_DRAIN: begin
        busy_d           = 1'b1;
        inst_d[MODE]     = mode_q;
        inst_d[OFIFO_RD] = rd_issue;
      end
      S_FIN:   done_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed bench for core_inst_seq; the watchdog test runs when SEQ_TIMEOUT_EN is defined.
module tb_core_inst_seq;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, cfg_mode_w, cfg_acc, ofifo_valid;
  logic [10:0] cfg_w_base, cfg_a_base, cfg_p_base, cfg_n_act;
  logic [34:0] inst;
  logic        busy, done, err;

  always #5 clk = ~clk;

  core_inst_seq #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cfg_mode_w  (cfg_mode_w),
    .cfg_acc     (cfg_acc),
    .cfg_w_base  (cfg_w_base),
    .cfg_a_base  (cfg_a_base),
    .cfg_p_base  (cfg_p_base),
    .cfg_n_act   (cfg_n_act),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  localparam int K_XR = 0, K_PR = 1, K_PW = 2, K_OR = 3, K_L0 = 4;
  localparam int K_LD = 5, K_IW = 6, K_EX = 7, K_ACC = 8, K_XW = 9;

  int checks = 0;
  int errors = 0;
  int ec[10][64];
  int ea[10][64];
  int en[10];
  int done_c, done_n, err_at_done, busy_at_done, busy_at0, err_at0, mode_at1;
  logic [63:0] ones = '1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic rec(input int k, input int c, input int a);
    if (en[k] < 64) begin
      ec[k][en[k]] = c;
      ea[k][en[k]] = a;
    end
    en[k]++;
  endtask

  task automatic run_tile(input int n, input int acc, input int mode, input int w, input int a,
                          input int p, input logic [63:0] vmask, input int pulse_at);
    for (int k = 0; k < 10; k++) en[k] = 0;
    done_c = -1; done_n = 0; err_at_done = -1; busy_at_done = -1; mode_at1 = -1;
    cfg_n_act = 11'(n); cfg_acc = acc[0]; cfg_mode_w = mode[0];
    cfg_w_base = 11'(w); cfg_a_base = 11'(a); cfg_p_base = 11'(p);
    ofifo_valid = vmask[0];
    start = 1'b1;
    tick;
    start = 1'b0;
    busy_at0 = int'(busy);
    err_at0 = int'(err);
    ofifo_valid = vmask[1];
    for (int c = 1; c <= 300; c++) begin
      tick;
      if (!inst[CEN_X]) rec(inst[WEN_X] ? K_XR : K_XW, c, int'(inst[A_X_LSB +: 11]));
      if (!inst[CEN_P]) rec(inst[WEN_P] ? K_PR : K_PW, c, int'(inst[A_P_LSB +: 11]));
      if (inst[OFIFO_RD]) rec(K_OR, c, 0);
      if (inst[L0_WR])    rec(K_L0, c, 0);
      if (inst[LOAD])     rec(K_LD, c, 0);
      if (inst[IFIFO_WR]) rec(K_IW, c, 0);
      if (inst[EXECUTE])  rec(K_EX, c, 0);
      if (inst[ACC])      rec(K_ACC, c, 0);
      if (c == 1) mode_at1 = int'(inst[MODE]);
      if (done) begin
        done_n++;
        if (done_c < 0) begin
          done_c = c;
          err_at_done = int'(err);
          busy_at_done = int'(busy);
        end
      end
      if (done_c >= 0 && c >= done_c + 2) break;
      start = (c == pulse_at);
      cfg_a_base = (c == pulse_at) ? 11'(a + 5) : 11'(a);
      cfg_n_act = (c == pulse_at) ? 11'd7 : 11'(n);
      ofifo_valid = (c < 63) ? vmask[c + 1] : 1'b0;
    end
    start = 1'b0;
    cfg_a_base = 11'(a);
    cfg_n_act = 11'(n);
    ofifo_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] m5;
    reset = 1'b0; start = 1'b1; cfg_mode_w = 1'b1; cfg_acc = 1'b1; ofifo_valid = 1'b1;
    cfg_w_base = '0; cfg_a_base = '0; cfg_p_base = '0; cfg_n_act = 11'd3;

    // T1 reset with start held high
    repeat (3) tick;
    chk("t1_inst", inst, INST_IDLE);
    chk("t1_busy", busy, 0);
    chk("t1_done", done, 0);
    chk("t1_err", err, 0);
    start = 1'b0; ofifo_valid = 1'b0; reset = 1'b1;
    repeat (2) tick;
    chk("t1_idle_after", inst, INST_IDLE);

    // T2 weight load only
    run_tile(0, 0, 0, 16, 0, 0, ones, -1);
    chk("t2_xr_n", en[K_XR], 8);
    chk("t2_xr_c0", ec[K_XR][0], 1);
    chk("t2_xr_a0", ea[K_XR][0], 16);
    chk("t2_xr_c7", ec[K_XR][7], 8);
    chk("t2_xr_a7", ea[K_XR][7], 23);
    chk("t2_l0_n", en[K_L0], 8);
    chk("t2_l0_c0", ec[K_L0][0], 2);
    chk("t2_ld_c0", ec[K_LD][0], 3);
    chk("t2_ld_c7", ec[K_LD][7], 10);
    chk("t2_ld_n", en[K_LD], 8);
    chk("t2_done_c", done_c, 11);
    chk("t2_done_n", done_n, 1);
    chk("t2_busy0", busy_at0, 1);
    chk("t2_busy_done", busy_at_done, 0);
    chk("t2_pw_n", en[K_PW], 0);
    chk("t2_err", err_at_done, 0);
    chk("t2_xw_n", en[K_XW], 0);
    tick;

    // T3 activations, no accumulate
    run_tile(4, 0, 1, 0, 100, 2040, ones, -1);
    chk("t3_xr_n", en[K_XR], 12);
    chk("t3_xr_c8", ec[K_XR][8], 11);
    chk("t3_xr_a8", ea[K_XR][8], 100);
    chk("t3_xr_c11", ec[K_XR][11], 14);
    chk("t3_xr_a11", ea[K_XR][11], 103);
    chk("t3_iw_c0", ec[K_IW][0], 12);
    chk("t3_iw_n", en[K_IW], 4);
    chk("t3_ex_c0", ec[K_EX][0], 13);
    chk("t3_ex_n", en[K_EX], 4);
    chk("t3_pw_n", en[K_PW], 4);
    chk("t3_pw_c0", ec[K_PW][0], 22);
    chk("t3_pw_a0", ea[K_PW][0], 2040);
    chk("t3_pw_c3", ec[K_PW][3], 25);
    chk("t3_pw_a3", ea[K_PW][3], 2043);
    chk("t3_pr_n", en[K_PR], 0);
    chk("t3_or_n", en[K_OR], 4);
    chk("t3_or_c0", ec[K_OR][0], 26);
    chk("t3_or_c3", ec[K_OR][3], 29);
    chk("t3_done_c", done_c, 30);
    chk("t3_mode1", mode_at1, 1);
    chk("t3_acc_n", en[K_ACC], 0);
    tick;

    // T4 accumulate, pmem address wraps past 2047
    run_tile(2, 1, 0, 0, 200, 2047, ones, -1);
    chk("t4_acc_n", en[K_ACC], 24);
    chk("t4_acc_c0", ec[K_ACC][0], 11);
    chk("t4_acc_c23", ec[K_ACC][23], 34);
    chk("t4_xr_c8", ec[K_XR][8], 11);
    chk("t4_xr_c9", ec[K_XR][9], 23);
    chk("t4_xr_a9", ea[K_XR][9], 201);
    chk("t4_pr_n", en[K_PR], 2);
    chk("t4_pr_c0", ec[K_PR][0], 12);
    chk("t4_pr_a0", ea[K_PR][0], 2047);
    chk("t4_pw_c0", ec[K_PW][0], 22);
    chk("t4_pw_a0", ea[K_PW][0], 2047);
    chk("t4_pr_c1", ec[K_PR][1], 24);
    chk("t4_pr_a1", ea[K_PR][1], 0);
    chk("t4_pw_c1", ec[K_PW][1], 34);
    chk("t4_pw_a1", ea[K_PW][1], 0);
    chk("t4_iw_c0", ec[K_IW][0], 12);
    chk("t4_ex_c0", ec[K_EX][0], 13);
    chk("t4_done_c", done_c, 37);
    chk("t4_mode1", mode_at1, 0);
    tick;

    // T7 reset in the middle of a tile
    cfg_n_act = 11'd2; cfg_acc = 1'b0; cfg_mode_w = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (6) tick;
    chk("t7_busy_mid", busy, 1);
    reset = 1'b0;
    tick;
    chk("t7_inst", inst, INST_IDLE);
    chk("t7_busy", busy, 0);
    reset = 1'b1;
    repeat (3) tick;
    chk("t7_inst_after", inst, INST_IDLE);
    chk("t7_done_after", done, 0);

    // T5 drain with gaps in ofifo_valid, start pulsed mid-tile
    m5 = '0;
    m5[25] = 1'b1; m5[27] = 1'b1; m5[28] = 1'b1;
    run_tile(3, 0, 0, 0, 40, 8, m5, 5);
    chk("t5_or_n", en[K_OR], 3);
    chk("t5_or_c0", ec[K_OR][0], 25);
    chk("t5_or_c1", ec[K_OR][1], 27);
    chk("t5_or_c2", ec[K_OR][2], 28);
    chk("t5_done_c", done_c, 29);
    chk("t5_done_n", done_n, 1);
    chk("t5_xr_n", en[K_XR], 11);
    chk("t5_xr_a8", ea[K_XR][8], 40);
    chk("t5_err", err_at_done, 0);
    tick;

`ifdef SEQ_TIMEOUT_EN
    // T6 watchdog: ofifo_valid never rises
    run_tile(1, 0, 0, 0, 10, 20, '0, -1);
    chk("t6_done_c", done_c, 39);
    chk("t6_err", err_at_done, 1);
    chk("t6_or_n", en[K_OR], 0);
    chk("t6_busy_done", busy_at_done, 0);
    chk("t6_err_held", err, 1);
    tick;
    run_tile(0, 0, 0, 0, 0, 0, ones, -1);
    chk("t6_err_clr", err_at0, 0);
    chk("t6_done2", done_c, 11);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
